// File: rtl/card_game_ctrl_if.sv
// card_game_ctrl_if -- button inputs and display/status outputs of the
// memory-pairs card game controller.
//   master : drives the three button pulses, observes the game state
//   slave  : the controller itself
// Signals:
//   btn_left / btn_right / btn_select : one-cycle synchronous pulses
//   card_states : face-up mask (flipped or matched)
//   cursor_pos  : one-hot cursor
//   matched     : permanently matched cards
//   move_count  : completed pair attempts, saturating at 255
//   busy        : pair being compared or mismatched pair on display
//   game_over   : all four cards matched
interface card_game_ctrl_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_select;
  logic [3:0] card_states;
  logic [3:0] cursor_pos;
  logic [3:0] matched;
  logic [7:0] move_count;
  logic       busy;
  logic       game_over;

  modport master (
    output btn_left, btn_right, btn_select,
    input  card_states, cursor_pos, matched, move_count, busy, game_over
  );

  modport slave (
    input  btn_left, btn_right, btn_select,
    output card_states, cursor_pos, matched, move_count, busy, game_over
  );
endinterface

// File: rtl/card_game_ctrl.sv
// card_game_ctrl -- four-card memory game. The player moves a one-hot cursor,
// flips two face-down cards, and the pair is either kept (equal values) or
// shown for HIDE_DELAY cycles and turned back face-down.
// Ports:
//   clk   : system clock, all state changes on its rising edge
//   reset : asynchronous, active-low reset
//   bus   : card_game_ctrl_if.slave (buttons in, registered game state out)
// Parameters:
//   HIDE_DELAY : cycles a mismatched pair stays face-up (1 .. 2^26-1)
//   PAIR_MAP   : card i value = PAIR_MAP[2i+1:2i]
module card_game_ctrl #(
  parameter int unsigned HIDE_DELAY = 50_000_000,
  parameter logic [7:0]  PAIR_MAP   = 8'h44
) (
  input  logic               clk,
  input  logic               reset,
  card_game_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    COMPARE,
    SHOW_MISMATCH,
    DONE
  } state_t;

  // The timer counts down to zero, so the last mismatch cycle is timer == 0.
  localparam logic [25:0] TIMER_LOAD = 26'(HIDE_DELAY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cursor_q, cursor_d;
  logic [3:0]  cards_q, cards_d;
  logic [3:0]  matched_q, matched_d;
  logic [7:0]  moves_q, moves_d;
  logic [25:0] timer_q, timer_d;
  logic [1:0]  first_q, first_d;
  logic [1:0]  second_q, second_d;
  logic        busy_q, busy_d;
  logic        game_over_q, game_over_d;

  logic [1:0]  sel_idx;
  logic        sel_free;
  logic [3:0]  pair_mask;

  function automatic logic [1:0] card_val(input logic [1:0] idx);
    return PAIR_MAP[{idx, 1'b0} +: 2];
  endfunction

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  // NOTE: every signal written here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    cards_d   = cards_q;
    matched_d = matched_q;
    moves_d   = moves_q;
    timer_d   = timer_q;
    first_d   = first_q;
    second_d  = second_q;

    // Selection always refers to the cursor as it was before this cycle's move.
    sel_idx   = onehot_idx(cursor_q);
    sel_free  = (cursor_q & cards_q) == 4'b0000;
    pair_mask = (4'b0001 << first_q) | (4'b0001 << second_q);

    if (bus.btn_right && !bus.btn_left) cursor_d = {cursor_q[2:0], cursor_q[3]};
    else if (bus.btn_left && !bus.btn_right) cursor_d = {cursor_q[0], cursor_q[3:1]};

    unique case (state_q)
      PICK1: begin
        if (bus.btn_select && sel_free) begin
          cards_d = cards_q | cursor_q;
          first_d = sel_idx;
          state_d = PICK2;
        end
      end
      PICK2: begin
        if (bus.btn_select && sel_free) begin
          cards_d  = cards_q | cursor_q;
          second_d = sel_idx;
          moves_d  = (moves_q == 8'hFF) ? moves_q : moves_q + 8'd1;
          state_d  = COMPARE;
        end
      end
      COMPARE: begin
        if (card_val(first_q) == card_val(second_q)) begin
          matched_d = matched_q | pair_mask;
          state_d   = (matched_d == 4'b1111) ? DONE : PICK1;
        end else begin
          timer_d = TIMER_LOAD;
          state_d = SHOW_MISMATCH;
        end
      end
      SHOW_MISMATCH: begin
        if (timer_q == 26'd0) begin
          cards_d = cards_q & ~pair_mask;
          state_d = PICK1;
        end else begin
          timer_d = timer_q - 26'd1;
        end
      end
      DONE: begin
        if (bus.btn_select) begin
          cards_d   = 4'b0000;
          matched_d = 4'b0000;
          moves_d   = 8'd0;
          cursor_d  = 4'b0001;
          state_d   = PICK1;
        end
      end
      default: state_d = PICK1;
    endcase

    // Status flags follow the next state so they are registered alongside it.
    busy_d      = (state_d == COMPARE) || (state_d == SHOW_MISMATCH);
    game_over_d = (state_d == DONE);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= PICK1;
      cursor_q    <= 4'b0001;
      cards_q     <= 4'b0000;
      matched_q   <= 4'b0000;
      moves_q     <= 8'd0;
      timer_q     <= 26'd0;
      first_q     <= 2'd0;
      second_q    <= 2'd0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cursor_q    <= cursor_d;
      cards_q     <= cards_d;
      matched_q   <= matched_d;
      moves_q     <= moves_d;
      timer_q     <= timer_d;
      first_q     <= first_d;
      second_q    <= second_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.card_states = cards_q;
  assign bus.cursor_pos  = cursor_q;
  assign bus.matched     = matched_q;
  assign bus.move_count  = moves_q;
  assign bus.busy        = busy_q;
  assign bus.game_over   = game_over_q;

endmodule
